// File: rtl/reg_bank_mp.sv
// Multi-port register bank: RD_PORTS combinational reads, two synchronous writes (W1 wins),
// a hardwired zero register, optional same-cycle write-to-read bypass and a per-register busy scoreboard.
module reg_bank_mp #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int RD_PORTS = 2,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [RD_PORTS*ADDR_W-1:0]   raddr_i,
    output logic [RD_PORTS*DATA_W-1:0]   rdata_o,
    output logic [RD_PORTS-1:0]          rbusy_o,
    input  logic                         w0_en_i,
    input  logic [ADDR_W-1:0]            w0_addr_i,
    input  logic [DATA_W-1:0]            w0_data_i,
    input  logic                         w1_en_i,
    input  logic [ADDR_W-1:0]            w1_addr_i,
    input  logic [DATA_W-1:0]            w1_data_i,
    input  logic                         issue_en_i,
    input  logic [ADDR_W-1:0]            issue_addr_i,
    output logic                         any_busy_o
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W:0]   NUM_A  = (ADDR_W + 1)'(NUM_REGS);
    localparam int                IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                w0_ok, w1_ok, iss_ok;
    logic [DATA_W-1:0]   regs_arr [NUM_REGS];
    logic [NUM_REGS-1:0] busy_vec;

    // Reset also gates the write/issue qualifiers so bypass cannot leak data while in reset.
    assign w0_ok  = rst_n_i && w0_en_i && (w0_addr_i != ZERO_A) && ({1'b0, w0_addr_i} < NUM_A);
    assign w1_ok  = rst_n_i && w1_en_i && (w1_addr_i != ZERO_A) && ({1'b0, w1_addr_i} < NUM_A);
    assign iss_ok = rst_n_i && issue_en_i && (issue_addr_i != ZERO_A) && ({1'b0, issue_addr_i} < NUM_A);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(g);

        logic              w0_hit, w1_hit, iss_hit;
        logic [DATA_W-1:0] data_q, data_d;
        logic              busy_q, busy_d;

        assign w0_hit  = w0_ok  && (w0_addr_i == IDX);
        assign w1_hit  = w1_ok  && (w1_addr_i == IDX);
        assign iss_hit = iss_ok && (issue_addr_i == IDX);

        always_comb begin
            data_d = data_q;
            busy_d = busy_q;
            if (w1_hit)
                data_d = w1_data_i;
            else if (w0_hit)
                data_d = w0_data_i;
            // A new producer issued in the same cycle as writeback keeps the register busy.
            if (iss_hit)
                busy_d = 1'b1;
            else if (w0_hit || w1_hit)
                busy_d = 1'b0;
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else begin
                data_q <= data_d;
                busy_q <= busy_d;
            end
        end

        assign regs_arr[g]  = data_q;
        assign busy_vec[g]  = busy_q;
    end

    assign any_busy_o = |busy_vec;

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [IDX_W-1:0]  ridx;
        logic              r_valid;
        logic [DATA_W-1:0] rd;
        logic              rb;

        assign ra      = raddr_i[p*ADDR_W +: ADDR_W];
        assign ridx    = ra[IDX_W-1:0];
        assign r_valid = (ra != ZERO_A) && ({1'b0, ra} < NUM_A);

        always_comb begin
            rd = '0;
            rb = 1'b0;
            if (r_valid) begin
                if ((BYPASS != 0) && w1_ok && (w1_addr_i == ra)) begin
                    rd = w1_data_i;
                    rb = iss_ok && (issue_addr_i == ra);
                end else if ((BYPASS != 0) && w0_ok && (w0_addr_i == ra)) begin
                    rd = w0_data_i;
                    rb = iss_ok && (issue_addr_i == ra);
                end else begin
                    rd = regs_arr[ridx];
                    rb = busy_vec[ridx];
                end
            end
        end

        assign rdata_o[p*DATA_W +: DATA_W] = rd;
        assign rbusy_o[p]                  = rb;
    end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed bench for reg_bank_mp: a bypass and a non-bypass instance share stimulus,
// plus a narrow 4-port / 16-register instance for the parametrisation checks.
module tb_reg_bank_mp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 64-bit, 2-port instances
    logic [9:0]   raddr;
    logic [127:0] rdata_nb, rdata_b;
    logic [1:0]   rbusy_nb, rbusy_b;
    logic         w0_en, w1_en, issue_en;
    logic [4:0]   w0_addr, w1_addr, issue_addr;
    logic [63:0]  w0_data, w1_data;
    logic         any_busy_nb, any_busy_b;

    // 32-bit, 4-port, 16-register instance
    logic [19:0]  p_raddr;
    logic [127:0] p_rdata;
    logic [3:0]   p_rbusy;
    logic         p_w0_en, p_w1_en, p_issue_en;
    logic [4:0]   p_w0_addr, p_w1_addr, p_issue_addr;
    logic [31:0]  p_w0_data, p_w1_data;
    logic         p_any_busy;

    int n_vec = 0;
    int n_err = 0;

    reg_bank_mp #(.BYPASS(0)) u_dut_nb (
        .clk_i(clk), .rst_n_i(rst_n), .raddr_i(raddr), .rdata_o(rdata_nb), .rbusy_o(rbusy_nb),
        .w0_en_i(w0_en), .w0_addr_i(w0_addr), .w0_data_i(w0_data),
        .w1_en_i(w1_en), .w1_addr_i(w1_addr), .w1_data_i(w1_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr), .any_busy_o(any_busy_nb)
    );

    reg_bank_mp #(.BYPASS(1)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
        .w0_en_i(w0_en), .w0_addr_i(w0_addr), .w0_data_i(w0_data),
        .w1_en_i(w1_en), .w1_addr_i(w1_addr), .w1_data_i(w1_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr), .any_busy_o(any_busy_b)
    );

    reg_bank_mp #(.DATA_W(32), .NUM_REGS(16), .RD_PORTS(4)) u_dut_p (
        .clk_i(clk), .rst_n_i(rst_n), .raddr_i(p_raddr), .rdata_o(p_rdata), .rbusy_o(p_rbusy),
        .w0_en_i(p_w0_en), .w0_addr_i(p_w0_addr), .w0_data_i(p_w0_data),
        .w1_en_i(p_w1_en), .w1_addr_i(p_w1_addr), .w1_data_i(p_w1_data),
        .issue_en_i(p_issue_en), .issue_addr_i(p_issue_addr), .any_busy_o(p_any_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        w0_en = 1'b0; w1_en = 1'b0; issue_en = 1'b0;
        p_w0_en = 1'b0; p_w1_en = 1'b0; p_issue_en = 1'b0;
    endtask

    // Advance through one rising edge and return on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        idle();
        raddr = '0; w0_addr = '0; w1_addr = '0; issue_addr = '0; w0_data = '0; w1_data = '0;
        p_raddr = '0; p_w0_addr = '0; p_w1_addr = '0; p_issue_addr = '0; p_w0_data = '0; p_w1_data = '0;

        @(negedge clk); #2;
        chk("rst_rdata",    rdata_b, 128'h0);
        chk("rst_rbusy",    {62'h0, rbusy_b}, 64'h0);
        chk("rst_any_busy", {63'h0, any_busy_b}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Plain write R5 via W0
        w0_en = 1'b1; w0_addr = 5'd5; w0_data = 64'hDEADBEEF_CAFEF00D;
        raddr = {5'd5, 5'd5};
        #2;
        chk("nb_same_cycle_old", rdata_nb[63:0], 64'h0);
        chk("b_same_cycle_fwd",  rdata_b[63:0],  64'hDEADBEEF_CAFEF00D);
        tick(); idle(); #2;
        chk("nb_r5_p0", rdata_nb[63:0],   64'hDEADBEEF_CAFEF00D);
        chk("nb_r5_p1", rdata_nb[127:64], 64'hDEADBEEF_CAFEF00D);

        // Dual write to R7, W1 must win
        w0_en = 1'b1; w0_addr = 5'd7; w0_data = 64'h11;
        w1_en = 1'b1; w1_addr = 5'd7; w1_data = 64'h22;
        raddr = {5'd5, 5'd7};
        #2;
        chk("b_dual_same",  rdata_b[63:0],  64'h22);
        chk("nb_dual_same", rdata_nb[63:0], 64'h0);
        tick(); idle(); #2;
        chk("b_dual_next",  rdata_b[63:0],  64'h22);
        chk("nb_dual_next", rdata_nb[63:0], 64'h22);
        chk("b_r5_p1",      rdata_b[127:64], 64'hDEADBEEF_CAFEF00D);

        // Zero register ignores writes and issues
        w0_en = 1'b1; w0_addr = 5'd31; w0_data = 64'hFFFF;
        issue_en = 1'b1; issue_addr = 5'd31;
        raddr = {5'd31, 5'd31};
        #2;
        chk("xzr_same_rdata", rdata_b[63:0], 64'h0);
        chk("xzr_same_rbusy", {63'h0, rbusy_b[0]}, 64'h0);
        tick(); idle(); #2;
        chk("xzr_rdata",    rdata_b[63:0], 64'h0);
        chk("xzr_rbusy",    {63'h0, rbusy_b[0]}, 64'h0);
        chk("xzr_any_busy", {63'h0, any_busy_b}, 64'h0);
        tick(); #2;
        chk("xzr_any_busy2", {63'h0, any_busy_b}, 64'h0);

        // Scoreboard on R9
        issue_en = 1'b1; issue_addr = 5'd9; raddr = {5'd9, 5'd9};
        #2;
        chk("sb_issue_same", {63'h0, rbusy_b[0]}, 64'h0);
        tick(); idle(); #2;
        chk("sb_busy",     {63'h0, rbusy_b[0]}, 64'h1);
        chk("sb_any_busy", {63'h0, any_busy_b}, 64'h1);
        w1_en = 1'b1; w1_addr = 5'd9; w1_data = 64'h5;
        #2;
        chk("sb_wb_b_rbusy",  {63'h0, rbusy_b[0]}, 64'h0);
        chk("sb_wb_b_rdata",  rdata_b[63:0], 64'h5);
        chk("sb_wb_nb_rbusy", {63'h0, rbusy_nb[0]}, 64'h1);
        tick(); idle(); #2;
        chk("sb_clr_any_b",  {63'h0, any_busy_b}, 64'h0);
        chk("sb_clr_any_nb", {63'h0, any_busy_nb}, 64'h0);
        issue_en = 1'b1; issue_addr = 5'd9;
        w0_en = 1'b1; w0_addr = 5'd9; w0_data = 64'h6;
        #2;
        chk("sb_iss_wb_rbusy", {63'h0, rbusy_b[0]}, 64'h1);
        chk("sb_iss_wb_rdata", rdata_b[63:0], 64'h6);
        tick(); idle(); #2;
        chk("sb_keep_busy",  {63'h0, rbusy_nb[0]}, 64'h1);
        chk("sb_keep_rdata", rdata_nb[63:0], 64'h6);
        chk("sb_keep_any",   {63'h0, any_busy_nb}, 64'h1);
        issue_en = 1'b1; issue_addr = 5'd9;
        tick(); idle(); #2;
        chk("sb_reissue", {63'h0, rbusy_b[1]}, 64'h1);

        // Asynchronous reset mid-cycle
        w0_en = 1'b1; w0_addr = 5'd3; w0_data = 64'h1234;
        tick(); idle();
        raddr = {5'd9, 5'd3};
        #2;
        chk("r3_before_rst", rdata_nb[63:0], 64'h1234);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_r3",   rdata_b[63:0], 64'h0);
        chk("async_rst_any",  {63'h0, any_busy_b}, 64'h0);
        chk("async_rst_busy", {62'h0, rbusy_b}, 64'h0);
        w0_en = 1'b1; w0_addr = 5'd3; w0_data = 64'h77;
        #0;
        chk("rst_bypass_blk", rdata_b[63:0], 64'h0);
        tick(); idle();
        chk("rst_drop_write", rdata_nb[63:0], 64'h0);
        rst_n = 1'b1;
        tick(); #2;
        chk("post_rst_r3", rdata_nb[63:0], 64'h0);

        // Narrow 4-port instance
        p_w0_en = 1'b1; p_w0_addr = 5'd0; p_w0_data = 32'hA0;
        p_w1_en = 1'b1; p_w1_addr = 5'd1; p_w1_data = 32'hB1;
        tick();
        p_w0_addr = 5'd2; p_w0_data = 32'hC2;
        p_w1_addr = 5'd3; p_w1_data = 32'hD3;
        tick(); idle();
        p_raddr = {5'd3, 5'd2, 5'd1, 5'd0};
        #2;
        chk("p_r0", {32'h0, p_rdata[31:0]},   64'hA0);
        chk("p_r1", {32'h0, p_rdata[63:32]},  64'hB1);
        chk("p_r2", {32'h0, p_rdata[95:64]},  64'hC2);
        chk("p_r3", {32'h0, p_rdata[127:96]}, 64'hD3);
        p_w0_en = 1'b1; p_w0_addr = 5'd20; p_w0_data = 32'hEE;
        p_issue_en = 1'b1; p_issue_addr = 5'd20;
        p_raddr = {5'd3, 5'd2, 5'd4, 5'd20};
        #2;
        chk("p_oor_same", {32'h0, p_rdata[31:0]}, 64'h0);
        tick(); idle(); #2;
        chk("p_oor_rdata", {32'h0, p_rdata[31:0]}, 64'h0);
        chk("p_oor_rbusy", {63'h0, p_rbusy[0]}, 64'h0);
        chk("p_no_alias",  {32'h0, p_rdata[63:32]}, 64'h0);
        chk("p_any_busy",  {63'h0, p_any_busy}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
- Parametrised multi-port successor to the single-write register bank in the ARM CPU datapath.
- Provides RD_PORTS combinational read ports and two synchronous write ports (W0 = ALU writeback, W1 = load writeback).
- Hardwires an architectural zero register (XZR) and offers optional same-cycle write-to-read bypass.
- Keeps a per-register busy scoreboard: the issue stage sets a bit, writeback clears it, and the stall logic reads it.

Parameters:
- DATA_W, 64, register data width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of registers (must be ≤ 2**ADDR_W)
- RD_PORTS, 2, number of read ports (1..4)
- ZERO_REG, 31, index that always reads 0; writes and issues to it are ignored
- BYPASS, 1, 1 = a same-cycle write is forwarded to the reads; 0 = reads return stored state only

Ports:
- CLK  input  1  clock, rising-edge active
- RST_N  input  1  reset, asynchronous, active-low
- RADDR  input  RD_PORTS*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- RDATA  output  RD_PORTS*DATA_W  packed read data
- RBUSY  output  RD_PORTS  per-port busy flag of the addressed register
- W0_EN  input  1  write port 0 enable
- W0_ADDR  input  ADDR_W  write port 0 address
- W0_DATA  input  DATA_W  write port 0 data
- W1_EN  input  1  write port 1 enable
- W1_ADDR  input  ADDR_W  write port 1 address
- W1_DATA  input  DATA_W  write port 1 data
- ISSUE_EN  input  1  mark destination register busy
- ISSUE_ADDR  input  ADDR_W  destination register being issued
- ANY_BUSY  output  1  OR of all busy bits

Behaviour:

Reset
- While RST_N = 0, immediately and independently of CLK: all registers = 0 and all busy bits = 0.
- Consequently RDATA = 0, RBUSY = 0 and ANY_BUSY = 0 during reset.
- Reset asserted mid-cycle overrides any pending write or issue.

Writes
- Take effect on the rising CLK edge when EN = 1 and ADDR ≠ ZERO_REG and ADDR < NUM_REGS; otherwise the write is dropped.
- If W0 and W1 target the same register in the same cycle, W1 wins.
- No #delay statements anywhere.

Busy scoreboard (per register, updated on the rising edge)
- Set when ISSUE_EN = 1 and ISSUE_ADDR matches, excluding ZERO_REG and out-of-range addresses.
- Otherwise cleared when either write port writes that register.
- Issue and writeback to the same register in the same cycle: the bit stays 1 (the new producer wins) and the data is still written.
- Issuing an already-busy register is legal and leaves the bit at 1.

Reads (combinational, zero latency)
- RADDR = ZERO_REG or ≥ NUM_REGS: RDATA = 0, RBUSY = 0.
- BYPASS = 1 and an enabled, valid write targets the read address this cycle:
  - RDATA = that write's data (W1 priority).
  - RBUSY = 0 unless ISSUE_EN targets the same register this cycle, in which case RBUSY = 1.
- Otherwise RDATA = stored value and RBUSY = stored busy bit.
- BYPASS = 0: no forwarding; new data is visible the cycle after the edge.

ANY_BUSY
- Registered OR of the busy bits; it does not include same-cycle issue or bypass effects.

Test Plan:
- Reset then read: drive RST_N = 0 mid-simulation after writing R3 = 0x1234 -> RDATA for R3 = 0 and ANY_BUSY = 0 immediately, without waiting for a clock edge.
- Basic write/read: W0 writes R5 = 0xDEADBEEF_CAFEF00D with BYPASS = 0 -> same-cycle read returns the old value 0; the cycle after the edge returns 0xDEADBEEF_CAFEF00D on both read ports.
- Bypass and dual-write conflict (BYPASS = 1): in one cycle W0 writes R7 = 0x11 and W1 writes R7 = 0x22 -> same-cycle RDATA = 0x22, next-cycle RDATA = 0x22.
- Zero register: W0 writes R31 = 0xFFFF and ISSUE_EN targets R31 -> RDATA(R31) = 0, RBUSY = 0 and ANY_BUSY = 0 on all following cycles.
- Scoreboard:
  - Issue R9 -> after the edge RBUSY(R9) = 1 and ANY_BUSY = 1.
  - Then W1 writes R9 = 0x5 -> in the same cycle (BYPASS = 1) RBUSY = 0 and RDATA = 0x5; after the edge ANY_BUSY = 0.
  - Then issue R9 while W0 writes R9 = 0x6 in the same cycle -> after the edge RBUSY(R9) = 1 and the stored value = 0x6.
- Parametrisation: build with RD_PORTS = 4, NUM_REGS = 16, DATA_W = 32 -> four independent reads of R0..R3 return their written values; a write to address 20 is dropped and a read of address 20 returns 0.
